// File: rtl/cmd_prefetch_manager.sv
// Command-fetch front end for one CPU context: reads the context IP, prefetches
// BURST command words into a DEPTH-entry FIFO for decode, then writes the IP back.
module cmd_prefetch_manager #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int IP_OFS = 1,
    parameter int BURST  = 4,
    parameter int DEPTH  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_in,
    input  logic          flush,
    input  logic [AW-1:0] flush_ip,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [DW-1:0] cmd_data,
    output logic [AW-1:0] base_addr,
    output logic          busy,
    output logic          done
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_IP,
        S_FETCH,
        S_WR_IP,
        S_FLUSH_WAIT
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ip_addr;
    logic [FW-1:0] fetched;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_inc, wr_ptr_inc;
    logic [CW-1:0] count;
    logic [DW-1:0] head_nxt;
    logic          ack, issue, push, pop, can_fetch, last_fetch;

    // An ack only counts while our request is up; stray or post-reset acks fall away here.
    assign ack        = bus_req & bus_ack;
    assign ip_addr    = base_addr + AW'(IP_OFS);
    assign can_fetch  = (state == S_FETCH) && (count < CW'(DEPTH));
    assign issue      = !bus_req && !flush &&
                        ((state == S_RD_IP) || (state == S_WR_IP) || can_fetch);
    assign push       = (state == S_FETCH) && ack && !flush;
    assign pop        = cmd_valid && cmd_ready && !flush;
    assign last_fetch = (fetched == FW'(BURST - 1));
    assign cmd_valid  = (count != '0);
    assign busy       = (state != S_IDLE);
    assign rd_ptr_inc = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    assign wr_ptr_inc = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            // Wait out an in-flight transaction before writing the redirected IP.
            state_nxt = (bus_req && !bus_ack) ? S_FLUSH_WAIT : S_WR_IP;
        end else begin
            case (state)
                S_IDLE:       if (start) state_nxt = S_RD_IP;
                S_RD_IP:      if (ack) state_nxt = S_FETCH;
                S_FETCH:      if (ack && last_fetch) state_nxt = S_WR_IP;
                S_WR_IP:      if (ack) state_nxt = S_IDLE;
                S_FLUSH_WAIT: if (ack) state_nxt = S_WR_IP;
                default:      state_nxt = S_IDLE;
            endcase
        end
    end

    // Bus outputs are registered at issue so they stay frozen until the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (ack) begin
            bus_req <= 1'b0;
        end else if (issue) begin
            bus_req   <= 1'b1;
            bus_we    <= (state == S_WR_IP);
            bus_addr  <= (state == S_FETCH) ? ptr : ip_addr;
            bus_wdata <= DW'(ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_addr <= '0;
            ptr       <= '0;
            fetched   <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == S_WR_IP) && ack && !flush;
            if ((state == S_IDLE) && start && !flush)
                base_addr <= base_in;
            if (flush) begin
                ptr <= flush_ip;
            end else if ((state == S_RD_IP) && ack) begin
                ptr     <= AW'(bus_rdata);
                fetched <= '0;
            end else if (push) begin
                ptr     <= ptr + AW'(1);
                fetched <= fetched + FW'(1);
            end
        end
    end

    // Head word is kept in a register; it tracks the next entry on pop or the
    // incoming word when the FIFO is (about to be) empty.
    always_comb begin
        head_nxt = cmd_data;
        if ((count == '0) || (pop && (count == CW'(1))))
            head_nxt = bus_rdata;
        else if (pop)
            head_nxt = mem[rd_ptr_inc];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            cmd_data <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr_inc;
            if (pop)  rd_ptr <= rd_ptr_inc;
            count    <= count + CW'(push) - CW'(pop);
            cmd_data <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop && (count == CW'(DEPTH))));
    end

endmodule
